// File: rtl/vscale_mem_arbiter_if.sv
// Signal bundle between the vscale core, the fetch/data arbiter and the shared memory port.
// The arbiter takes the master modport (it masters the shared port); the environment takes slave.
interface vscale_mem_arbiter_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_wait;
  logic        imem_badmem_e;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [2:0]  mem_req_size;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  modport master (
    input  imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    output imem_rdata, imem_wait, imem_badmem_e, dmem_rdata, dmem_wait, dmem_badmem_e,
    output mem_req_valid, mem_req_wen, mem_req_size, mem_req_addr, mem_req_wdata
  );

  modport slave (
    output imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    input  imem_rdata, imem_wait, imem_badmem_e, dmem_rdata, dmem_wait, dmem_badmem_e,
    input  mem_req_valid, mem_req_wen, mem_req_size, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/vscale_mem_arbiter.sv
// Serializes the vscale fetch and data requests onto one single-outstanding memory port.
// Define VSCALE_ARB_FETCH_FIRST_EN to issue the fetch before the data access.
module vscale_mem_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  vscale_mem_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE1, RESP1, ISSUE2, RESP2} state_e;

  localparam logic [2:0] FETCH_SIZE = 3'd2;

  state_e      state_q, state_d;
  logic [31:0] i_addr_q;
  logic        d_pend_q;
  logic        d_wen_q;
  logic [2:0]  d_size_q;
  logic [31:0] d_addr_q;
  logic [31:0] wdata_q;
  logic        first_q;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;
  logic        busy;
  logic        second;
  logic        sel_data;
  logic        take_resp;

  assign busy      = (state_q != IDLE);
  assign second    = (state_q == ISSUE2) || (state_q == RESP2);
  assign take_resp = bus.mem_resp_valid && ((state_q == RESP1) || (state_q == RESP2));

`ifdef VSCALE_ARB_FETCH_FIRST_EN
  // The second slot only exists when a data access is pending, so it is always the data one.
  assign sel_data          = second;
  assign bus.mem_req_wdata = wdata_q;
`else
  assign sel_data          = d_pend_q && !second;
  // Store data arrives one cycle after the address, which is exactly the first ISSUE1 cycle.
  assign bus.mem_req_wdata = first_q ? bus.dmem_wdata_delayed : wdata_q;
`endif

  assign bus.imem_wait     = busy;
  assign bus.dmem_wait     = busy && d_pend_q;
  assign bus.imem_rdata    = i_rdata_q;
  assign bus.imem_badmem_e = i_err_q;
  assign bus.dmem_rdata    = d_rdata_q;
  assign bus.dmem_badmem_e = d_err_q;

  always_comb begin
    state_d           = state_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_wen   = 1'b0;
    bus.mem_req_size  = FETCH_SIZE;
    bus.mem_req_addr  = i_addr_q;
    i_rdata_d         = i_rdata_q;
    i_err_d           = i_err_q;
    d_rdata_d         = d_rdata_q;
    d_err_d           = d_err_q;

    if (sel_data) begin
      bus.mem_req_wen  = d_wen_q;
      bus.mem_req_size = d_size_q;
      bus.mem_req_addr = d_addr_q;
    end

    unique case (state_q)
      IDLE:   state_d = ISSUE1;
      ISSUE1: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = RESP1;
      end
      RESP1:  if (bus.mem_resp_valid) state_d = d_pend_q ? ISSUE2 : IDLE;
      ISSUE2: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = RESP2;
      end
      RESP2:  if (bus.mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A store response only carries an error flag; the load data register is left alone.
    if (take_resp) begin
      if (sel_data) begin
        d_err_d = bus.mem_resp_err;
        if (!d_wen_q) d_rdata_d = bus.mem_resp_rdata;
      end else begin
        i_err_d   = bus.mem_resp_err;
        i_rdata_d = bus.mem_resp_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      i_addr_q  <= '0;
      d_pend_q  <= 1'b0;
      d_wen_q   <= 1'b0;
      d_size_q  <= '0;
      d_addr_q  <= '0;
      wdata_q   <= '0;
      first_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= (state_q == IDLE);
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      if (state_q == IDLE) begin
        i_addr_q <= bus.imem_addr;
        d_pend_q <= bus.dmem_en;
        d_wen_q  <= bus.dmem_wen;
        d_size_q <= bus.dmem_size;
        d_addr_q <= bus.dmem_addr;
      end
      if (first_q && d_pend_q) wdata_q <= bus.dmem_wdata_delayed;
    end
  end
endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Randomized and directed bench for vscale_mem_arbiter, acting as both core and memory.
// Honours VSCALE_ARB_FETCH_FIRST_EN for the expected issue order.
module tb_vscale_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vscale_mem_arbiter_if bus_if ();
  vscale_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus_if));

  int total = 0;
  int bad   = 0;
  int txn_n = 0;

  logic [31:0] exp_i_rdata, exp_d_rdata;
  logic        exp_i_err, exp_d_err;

  typedef struct {
    logic        is_data;
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stall;
    int          rdly;
  } acc_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_imem_wait"}, bus_if.imem_wait, 1'b0);
    chk({tag, "_dmem_wait"}, bus_if.dmem_wait, 1'b0);
    chk({tag, "_req_valid"}, bus_if.mem_req_valid, 1'b0);
    chk({tag, "_imem_rdata"}, bus_if.imem_rdata, exp_i_rdata);
    chk({tag, "_dmem_rdata"}, bus_if.dmem_rdata, exp_d_rdata);
    chk({tag, "_imem_err"}, bus_if.imem_badmem_e, exp_i_err);
    chk({tag, "_dmem_err"}, bus_if.dmem_badmem_e, exp_d_err);
  endtask

  // Entered just after a negedge with the DUT in its delivery (IDLE) cycle; leaves the same way.
  task automatic run_txn(input logic den, input logic dwen, input logic [2:0] dsize,
                         input logic [31:0] daddr, input logic [31:0] iaddr,
                         input logic [31:0] wdata, input logic [31:0] i_rd,
                         input logic [31:0] d_rd, input logic i_er, input logic d_er,
                         input int i_stall, input int d_stall, input int i_rdly, input int d_rdly);
    acc_t q[$];
    acc_t fa, da, a;
    logic first;
    fa = '{is_data: 1'b0, wen: 1'b0, size: 3'd0, addr: iaddr, wdata: 32'd0,
           rdata: i_rd, err: i_er, stall: i_stall, rdly: i_rdly};
    da = '{is_data: 1'b1, wen: dwen, size: dsize, addr: daddr, wdata: wdata,
           rdata: d_rd, err: d_er, stall: d_stall, rdly: d_rdly};
    if (!den) q.push_back(fa);
    else begin
`ifdef VSCALE_ARB_FETCH_FIRST_EN
      q.push_back(fa);
      q.push_back(da);
`else
      q.push_back(da);
      q.push_back(fa);
`endif
    end

    bus_if.imem_addr          = iaddr;
    bus_if.dmem_en            = den;
    bus_if.dmem_wen           = dwen;
    bus_if.dmem_size          = dsize;
    bus_if.dmem_addr          = daddr;
    bus_if.dmem_wdata_delayed = $urandom;
    bus_if.mem_req_ready      = 1'b0;
    bus_if.mem_resp_valid     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    first = 1'b1;

    for (int k = 0; k < q.size(); k++) begin
      a = q[k];
      for (int c = 0; c <= a.stall; c++) begin
        bus_if.dmem_wdata_delayed = first ? wdata : $urandom;
        bus_if.mem_req_ready      = (c == a.stall);
        // Stray responses while issuing must be ignored.
        bus_if.mem_resp_valid     = ($urandom_range(0, 3) == 0);
        bus_if.mem_resp_rdata     = $urandom;
        bus_if.mem_resp_err       = 1'($urandom_range(0, 1));
        #1;
        chk("req_valid", bus_if.mem_req_valid, 1'b1);
        chk("req_addr", bus_if.mem_req_addr, a.addr);
        chk("req_wen", bus_if.mem_req_wen, a.wen);
        if (a.is_data) chk("req_size", bus_if.mem_req_size, a.size);
        if (a.is_data && a.wen) chk("req_wdata", bus_if.mem_req_wdata, a.wdata);
        chk("busy_imem_wait", bus_if.imem_wait, 1'b1);
        chk("busy_dmem_wait", bus_if.dmem_wait, den);
        @(posedge clk);
        @(negedge clk);
        first = 1'b0;
      end
      for (int d = 0; d <= a.rdly; d++) begin
        bus_if.dmem_wdata_delayed = $urandom;
        bus_if.mem_req_ready      = 1'b0;
        bus_if.mem_resp_valid     = (d == a.rdly);
        bus_if.mem_resp_rdata     = a.rdata;
        bus_if.mem_resp_err       = a.err;
        #1;
        chk("resp_req_valid", bus_if.mem_req_valid, 1'b0);
        chk("resp_imem_wait", bus_if.imem_wait, 1'b1);
        chk("resp_dmem_wait", bus_if.dmem_wait, den);
        @(posedge clk);
        @(negedge clk);
      end
      if (a.is_data) begin
        exp_d_err = a.err;
        if (!a.wen) exp_d_rdata = a.rdata;
      end else begin
        exp_i_err   = a.err;
        exp_i_rdata = a.rdata;
      end
    end

    bus_if.mem_req_ready  = 1'b0;
    bus_if.mem_resp_valid = 1'b0;
    #1;
    check_idle("deliver");
    txn_n++;
    $display("txn %0d: den=%0d wen=%0d iaddr=0x%08h daddr=0x%08h irdata=0x%08h drdata=0x%08h ierr=%0d derr=%0d",
             txn_n, den, dwen, iaddr, daddr, bus_if.imem_rdata, bus_if.dmem_rdata,
             bus_if.imem_badmem_e, bus_if.dmem_badmem_e);
  endtask

  task automatic reset_mid();
    bus_if.imem_addr      = 32'h300;
    bus_if.dmem_en        = 1'b1;
    bus_if.dmem_wen       = 1'b0;
    bus_if.dmem_size      = 3'd2;
    bus_if.dmem_addr      = 32'h1000;
    bus_if.mem_req_ready  = 1'b0;
    bus_if.mem_resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_if.mem_req_ready = 1'b1;
    #1;
    chk("rm_issue_valid", bus_if.mem_req_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus_if.mem_req_ready = 1'b0;
    #1;
    chk("rm_resp1_dwait", bus_if.dmem_wait, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_i_rdata = 32'd0;
    exp_d_rdata = 32'd0;
    exp_i_err   = 1'b0;
    exp_d_err   = 1'b0;
    #1;
    check_idle("rm_after");
    txn_n++;
    $display("txn %0d: reset during RESP1", txn_n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset                     = 1'b1;
    bus_if.imem_addr          = '0;
    bus_if.dmem_en            = 1'b0;
    bus_if.dmem_wen           = 1'b0;
    bus_if.dmem_size          = '0;
    bus_if.dmem_addr          = '0;
    bus_if.dmem_wdata_delayed = '0;
    bus_if.mem_req_ready      = 1'b0;
    bus_if.mem_resp_valid     = 1'b0;
    bus_if.mem_resp_rdata     = '0;
    bus_if.mem_resp_err       = 1'b0;
    exp_i_rdata = 32'd0;
    exp_d_rdata = 32'd0;
    exp_i_err   = 1'b0;
    exp_d_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("reset");

    // Fetch only, then load plus fetch.
    run_txn(1'b0, 1'b0, 3'd2, 32'h0, 32'h200, 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 0, 0, 0, 0);
    run_txn(1'b1, 1'b0, 3'd2, 32'h1000, 32'h200, 32'h0, 32'h13, 32'hDEADBEEF,
            1'b0, 1'b0, 0, 0, 0, 0);
    // Store with a three-cycle ready stall; load data must be held.
    run_txn(1'b1, 1'b1, 3'd2, 32'h2004, 32'h204, 32'hCAFEF00D, 32'h13, 32'h55AA55AA,
            1'b0, 1'b0, 0, 3, 0, 0);
    // Fetch error, then a clean access clears both flags.
    run_txn(1'b1, 1'b0, 3'd2, 32'h1008, 32'h208, 32'h0, 32'h0BADF00D, 32'h12345678,
            1'b1, 1'b0, 0, 0, 1, 2);
    run_txn(1'b1, 1'b0, 3'd2, 32'h100C, 32'h20C, 32'h0, 32'h13, 32'h87654321,
            1'b0, 1'b0, 0, 0, 0, 0);
    reset_mid();
    run_txn(1'b1, 1'b0, 3'd2, 32'h1000, 32'h200, 32'h0, 32'h13, 32'hDEADBEEF,
            1'b0, 1'b0, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
